la_serial_adder_stage: RTL and testbench

//  User-project stage feeding the mprj_io check bus. Mgmt core loads two operands over the LA,

---
 rtl/la_serial_adder_stage_if.sv | 25 ++
 rtl/la_serial_adder_stage.sv | 156 +++++++++++++++
 tb/tb_la_serial_adder_stage.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/la_serial_adder_stage_if.sv
// Logic-analyser and user-IO bundle between the management side and the serial adder stage.
// The master side drives the LA inputs and observes the LA readback and the IO status pins.
interface la_serial_adder_stage_if;
    logic [127:0] la_data_in;
    logic [127:0] la_oenb;
    logic [127:0] la_data_out;
    logic [37:0]  io_out;
    logic [37:0]  io_oeb;

    modport master (
        output la_data_in,
        output la_oenb,
        input  la_data_out,
        input  io_out,
        input  io_oeb
    );

    modport slave (
        input  la_data_in,
        input  la_oenb,
        output la_data_out,
        output io_out,
        output io_oeb
    );
endinterface

// File: rtl/la_serial_adder_stage.sv
// Bit-serial adder loaded over the LA; publishes its busy/done status word on io_out[31:16].
// Optional macro LA_EXPECT_CHECK_EN adds a compare of the sum against an LA-supplied expected value.
module la_serial_adder_stage #(
    parameter int unsigned WIDTH    = 32,
    parameter logic [15:0] ST_START = 16'hAB60,
    parameter logic [15:0] ST_DONE  = 16'hAB61,
    parameter logic [15:0] ST_FAIL  = 16'hAB6F
) (
    input  logic                    clock,
    input  logic                    resetb,
    la_serial_adder_stage_if.slave  bus
);
    localparam int unsigned          CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]     LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ADD, S_DONE} state_t;

    state_t             state_q, state_d;
    logic               start_q, start_prev_q, clear_q;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, psum_q, psum_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH:0]     sum_q, sum_d;
    logic [15:0]        status_q, status_d;

    logic [31:0]        a_in, b_in;
    logic               start_edge, s_bit, c_next, load_entry, done_entry, mism_flag;
    logic [WIDTH:0]     sum_full;
    logic [15:0]        done_status;
    logic [127:0]       la_out;

    // Operand bits not driven by management read as zero.
    assign a_in       = bus.la_data_in[31:0]  & ~bus.la_oenb[31:0];
    assign b_in       = bus.la_data_in[63:32] & ~bus.la_oenb[63:32];
    assign start_edge = start_q & ~start_prev_q;

    assign s_bit      = a_q[0] ^ b_q[0] ^ carry_q;
    assign c_next     = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
    assign sum_full   = {c_next, s_bit, psum_q[WIDTH-1:1]};

    assign load_entry = !clear_q && (state_q == S_IDLE || state_q == S_DONE) && start_edge;
    assign done_entry = !clear_q && (state_q == S_ADD) && (cnt_q == LAST_CNT);

`ifdef LA_EXPECT_CHECK_EN
    logic [WIDTH-1:0] exp_in;
    logic             mism_now, mism_q;
    logic             unused_in;

    assign exp_in      = bus.la_data_in[96 +: WIDTH] & ~bus.la_oenb[96 +: WIDTH];
    assign mism_now    = (sum_full[WIDTH-1:0] != exp_in);
    assign done_status = mism_now ? ST_FAIL : ST_DONE;
    assign mism_flag   = mism_q;
    assign unused_in   = ^{bus.la_data_in, bus.la_oenb};

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            mism_q <= 1'b0;
        end else if (clear_q || load_entry) begin
            mism_q <= 1'b0;
        end else if (done_entry) begin
            mism_q <= mism_now;
        end
    end
`else
    logic unused_in;

    assign done_status = ST_DONE;
    assign mism_flag   = 1'b0;
    assign unused_in   = ^{bus.la_data_in, bus.la_oenb, ST_FAIL};
`endif

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_q      <= S_IDLE;
            start_q      <= 1'b0;
            start_prev_q <= 1'b0;
            clear_q      <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            psum_q       <= '0;
            carry_q      <= 1'b0;
            cnt_q        <= '0;
            sum_q        <= '0;
            status_q     <= '0;
        end else begin
            state_q      <= state_d;
            start_q      <= bus.la_data_in[64] & ~bus.la_oenb[64];
            start_prev_q <= start_q;
            clear_q      <= bus.la_data_in[65] & ~bus.la_oenb[65];
            a_q          <= a_d;
            b_q          <= b_d;
            psum_q       <= psum_d;
            carry_q      <= carry_d;
            cnt_q        <= cnt_d;
            sum_q        <= sum_d;
            status_q     <= status_d;
        end
    end

    // Clear overrides everything, including a start edge in the same cycle.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        psum_d   = psum_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        status_d = status_q;
        if (clear_q) begin
            state_d  = S_IDLE;
            status_d = '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (load_entry) begin
                        state_d  = S_LOAD;
                        a_d      = a_in[WIDTH-1:0];
                        b_d      = b_in[WIDTH-1:0];
                        psum_d   = '0;
                        carry_d  = 1'b0;
                        cnt_d    = '0;
                        status_d = ST_START;
                    end
                end
                S_LOAD: state_d = S_ADD;
                S_ADD: begin
                    a_d     = a_q >> 1;
                    b_d     = b_q >> 1;
                    psum_d  = {s_bit, psum_q[WIDTH-1:1]};
                    carry_d = c_next;
                    cnt_d   = cnt_q + 1'b1;
                    // The visible sum only changes here, never with partial bits.
                    if (done_entry) begin
                        state_d  = S_DONE;
                        sum_d    = sum_full;
                        status_d = done_status;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        la_out            = '0;
        la_out[WIDTH:0]   = sum_q;
        la_out[64]        = (state_q == S_LOAD) || (state_q == S_ADD);
        la_out[65]        = (state_q == S_DONE);
        la_out[66]        = mism_flag;
    end

    assign bus.la_data_out = la_out;
    assign bus.io_out      = {6'b0, status_q, 16'b0};
    assign bus.io_oeb      = {6'h3F, 16'h0000, 16'hFFFF};
endmodule

// File: tb/tb_la_serial_adder_stage.sv
// Bench for la_serial_adder_stage: operand table with a sum scoreboard, plus hand-written
// sequences for start-while-busy, clear, oenb gating, reset mid-operation and the expect check.
module tb_la_serial_adder_stage;
    localparam int          W        = 32;
    localparam logic [15:0] ST_START = 16'hAB60;
    localparam logic [15:0] ST_DONE  = 16'hAB61;
    localparam logic [15:0] ST_FAIL  = 16'hAB6F;

    logic        clock  = 1'b0;
    logic        resetb = 1'b0;
    int          errors = 0;
    int          checks = 0;
    logic [32:0] sb[$];
    logic [32:0] last_exp = '0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] oen;
        logic [32:0] sum;
    } vec_t;

    vec_t vecs[8];

    la_serial_adder_stage_if bus();

    la_serial_adder_stage #(.WIDTH(W)) dut (
        .clock  (clock),
        .resetb (resetb),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic start_op(input logic [31:0] a, input logic [31:0] b,
                            input logic [63:0] oen, input logic [31:0] expv);
        bus.la_data_in[63:0]   = {b, a};
        bus.la_oenb[63:0]      = oen;
        bus.la_data_in[127:96] = expv;
        bus.la_data_in[64]     = 1'b1;
        @(posedge clock);
        #1;
        bus.la_data_in[64]     = 1'b0;
    endtask

    // poke > 0 raises start again at that cycle count (while the add is running).
    task automatic wait_done(input string name, input logic [15:0] st, input logic flag,
                             input int poke);
        int          k = 0;
        logic [32:0] req;
        do begin
            @(posedge clock);
            @(negedge clock);
            k++;
            if (k == 1)
                check({name, "_load"}, 128'({bus.la_data_out[65:64], bus.io_out[31:16]}),
                      128'({2'b01, ST_START}));
            if (poke != 0 && k == poke) bus.la_data_in[64] = 1'b1;
            if (poke != 0 && k == poke + 1) begin
                bus.la_data_in[64]   = 1'b0;
                bus.la_data_in[63:0] = '0;
            end
        end while (bus.la_data_out[65] !== 1'b1 && k < 200);
        check({name, "_latency"}, 128'(k), 128'(W + 2));
        req = 'x;
        if (sb.size() != 0) req = sb.pop_front();
        check({name, "_sum"}, 128'(bus.la_data_out[32:0]), 128'(req));
        check({name, "_status"}, 128'({bus.la_data_out[66:64], bus.io_out[31:16]}),
              128'({flag, 2'b10, st}));
        last_exp = req;
    endtask

    initial begin
        vecs[0] = '{32'd5,         32'd7,         64'd0,                  33'd12};
        vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0,                  33'h1_FFFF_FFFE};
        vecs[2] = '{32'd0,         32'd0,         64'd0,                  33'd0};
        vecs[3] = '{32'hFFFF_FFFF, 32'd1,         64'd0,                  33'h1_0000_0000};
        vecs[4] = '{32'h8000_0000, 32'h8000_0000, 64'd0,                  33'h1_0000_0000};
        vecs[5] = '{32'h1234_5678, 32'h1111_1111, 64'd0,                  33'h0_2345_6789};
        vecs[6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_0000_0000_FFFF, 33'h0_FFFF_FFFF};
        vecs[7] = '{32'hDEAD_BEEF, 32'h2152_4111, 64'd0,                  33'h1_0000_0000};

        bus.la_data_in = '0;
        bus.la_oenb    = '1;
        resetb         = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_la_out", bus.la_data_out, 128'd0);
        check("reset_io_out", 128'(bus.io_out), 128'd0);
        check("reset_io_oeb", 128'(bus.io_oeb), 128'({6'h3F, 16'h0000, 16'hFFFF}));
        resetb      = 1'b1;
        bus.la_oenb = '0;
        repeat (2) @(negedge clock);
        check("idle_after_reset", 128'({bus.la_data_out[65:64], bus.io_out[31:16]}), 128'd0);

        // Back-to-back table: every op after the first starts from DONE.
        for (int i = 0; i < 8; i++) begin
            sb.push_back(vecs[i].sum);
            start_op(vecs[i].a, vecs[i].b, vecs[i].oen, vecs[i].sum[31:0]);
            wait_done($sformatf("vec%0d", i), ST_DONE, 1'b0, 0);
        end
        bus.la_oenb = '0;

        // Second start edge during ADD is ignored; operands changed after capture too.
        sb.push_back(33'h1_FFFF_FFFE);
        start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, 32'hFFFF_FFFE);
        wait_done("restart_ignored", ST_DONE, 1'b0, 5);
        repeat (3) @(negedge clock);
        check("done_holds", 128'({bus.la_data_out[65:64], bus.io_out[31:16], bus.la_data_out[32:0]}),
              128'({2'b10, ST_DONE, last_exp}));

        // Clear and start edge together mid-add: clear wins, sum retained.
        start_op(32'h0000_1234, 32'h0000_0001, 64'd0, 32'd0);
        repeat (6) @(negedge clock);
        bus.la_data_in[65] = 1'b1;
        bus.la_data_in[64] = 1'b1;
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        check("clear_status", 128'({bus.la_data_out[66:64], bus.io_out[31:16]}), 128'd0);
        check("clear_sum_kept", 128'(bus.la_data_out[32:0]), 128'(last_exp));
        bus.la_data_in[65] = 1'b0;
        bus.la_data_in[64] = 1'b0;
        repeat (4) @(negedge clock);
        check("clear_idle_stays", 128'({bus.la_data_out[65:64], bus.io_out[31:16]}), 128'd0);

        // Start bit toggled while its oenb is high never starts an op.
        bus.la_oenb[64] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.la_data_in[64] = (i % 2 == 0);
            @(negedge clock);
        end
        check("oenb_gate_mid", 128'({bus.la_data_out[65:64], bus.io_out[31:16]}), 128'd0);
        bus.la_data_in[64] = 1'b0;
        @(negedge clock);
        bus.la_oenb[64] = 1'b0;
        repeat (3) @(negedge clock);
        check("oenb_gate_end", 128'({bus.la_data_out[65:64], bus.io_out[31:16]}), 128'd0);

        // Reset mid-operation: outputs drop immediately, nothing partial comes back.
        start_op(32'd100, 32'd200, 64'd0, 32'd300);
        repeat (10) @(negedge clock);
        resetb = 1'b0;
        #1;
        check("rst_mid_la_out", bus.la_data_out, 128'd0);
        check("rst_mid_io_out", 128'(bus.io_out), 128'd0);
        @(negedge clock);
        resetb = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_mid_after", bus.la_data_out, 128'd0);

        // Fresh op from IDLE after the reset.
        sb.push_back(33'd12);
        start_op(32'd5, 32'd7, 64'd0, 32'd12);
        wait_done("after_reset", ST_DONE, 1'b0, 0);

`ifdef LA_EXPECT_CHECK_EN
        sb.push_back(33'd7);
        start_op(32'd3, 32'd4, 64'd0, 32'd8);
        wait_done("expect_bad", ST_FAIL, 1'b1, 0);
        sb.push_back(33'd7);
        start_op(32'd3, 32'd4, 64'd0, 32'd7);
        wait_done("expect_good", ST_DONE, 1'b0, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
